// File: rtl/map_ss_seq.sv
// rtl/map_ss_seq.sv - save-state sequencer walking the mapper state window for SAVE/LOAD
module map_ss_seq #(
    parameter int SS_LEN = 128,
    parameter int RD_LAT = 2,
    parameter int M2_TMO = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_save,
    input  logic       start_load,
    input  logic       abort,
    input  logic       m2_fall,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat,
    output logic       o_valid,
    input  logic       o_ready,
    output logic [7:0] o_data,
    input  logic       i_valid,
    output logic       i_ready,
    input  logic [7:0] i_data,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int               CNT_MAX   = (M2_TMO > RD_LAT) ? M2_TMO : RD_LAT;
    localparam int               CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [7:0]       LAST_ADDR = 8'(SS_LEN - 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(M2_TMO - 1);

    typedef enum logic [2:0] {
        IDLE, S_SET, S_WAIT, S_PUSH, L_PULL, L_ARM, L_HOLD, FIN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ss_act_q, ss_act_d;
    logic             ss_we_q, ss_we_d;
    logic [7:0]       ss_addr_q, ss_addr_d;
    logic [7:0]       ss_wdat_q, ss_wdat_d;
    logic             o_valid_q, o_valid_d;
    logic [7:0]       o_data_q, o_data_d;
    logic             i_ready_q, i_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ss_act_d  = ss_act_q;
        ss_we_d   = ss_we_q;
        ss_addr_d = ss_addr_q;
        ss_wdat_d = ss_wdat_q;
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        i_ready_d = i_ready_q;
        err_d     = err_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_save || start_load) begin
                    err_d     = 1'b0;
                    ss_addr_d = 8'd0;
                    cnt_d     = '0;
                    ss_act_d  = 1'b1;
                    if (start_save) begin
                        state_d = S_SET;
                    end else begin
                        state_d   = L_PULL;
                        i_ready_d = 1'b1;
                    end
                end
            end
            S_SET: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Read data is sampled only after RD_LAT full cycles have elapsed since the address moved.
                if (cnt_q == RD_LAST) begin
                    o_data_d  = ss_rdat;
                    o_valid_d = 1'b1;
                    state_d   = S_PUSH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PUSH: begin
                if (o_ready) begin
                    o_valid_d = 1'b0;
                    if (ss_addr_q == LAST_ADDR) begin
                        ss_act_d = 1'b0;
                        done_d   = 1'b1;
                        state_d  = FIN;
                    end else begin
                        ss_addr_d = ss_addr_q + 8'd1;
                        state_d   = S_SET;
                    end
                end
            end
            L_PULL: begin
                if (i_valid) begin
                    i_ready_d = 1'b0;
                    ss_wdat_d = i_data;
                    ss_we_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = L_ARM;
                end
            end
            L_ARM: begin
                if (m2_fall) begin
                    state_d = L_HOLD;
                end else if (cnt_q == TMO_LAST) begin
                    err_d    = 1'b1;
                    ss_we_d  = 1'b0;
                    ss_act_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            L_HOLD: begin
                ss_we_d = 1'b0;
                if (ss_addr_q == LAST_ADDR) begin
                    ss_act_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = FIN;
                end else begin
                    ss_addr_d = ss_addr_q + 8'd1;
                    i_ready_d = 1'b1;
                    state_d   = L_PULL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort drops the operation wholesale; any unaccepted save beat is simply lost.
        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            cnt_d     = '0;
            ss_act_d  = 1'b0;
            ss_we_d   = 1'b0;
            ss_addr_d = 8'd0;
            o_valid_d = 1'b0;
            i_ready_d = 1'b0;
            done_d    = 1'b0;
            err_d     = err_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ss_act_q  <= 1'b0;
            ss_we_q   <= 1'b0;
            ss_addr_q <= 8'd0;
            ss_wdat_q <= 8'd0;
            o_valid_q <= 1'b0;
            o_data_q  <= 8'd0;
            i_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ss_act_q  <= ss_act_d;
            ss_we_q   <= ss_we_d;
            ss_addr_q <= ss_addr_d;
            ss_wdat_q <= ss_wdat_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            i_ready_q <= i_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ss_act  = ss_act_q;
    assign ss_we   = ss_we_q;
    assign ss_addr = ss_addr_q;
    assign ss_wdat = ss_wdat_q;
    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign i_ready = i_ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
endmodule

// File: tb/tb_map_ss_seq.sv
// tb/tb_map_ss_seq.sv - randomized self-checking bench for map_ss_seq against a mapper/host model
module tb_map_ss_seq;
    localparam int SS_LEN = 4;
    localparam int RD_LAT = 2;
    localparam int M2_TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_save = 1'b0, start_load = 1'b0, abort = 1'b0, m2_fall = 1'b0;
    logic       ss_act, ss_we, o_valid, i_ready, busy, done, err;
    logic [7:0] ss_addr, ss_wdat, ss_rdat, o_data;
    logic       o_ready = 1'b0, i_valid = 1'b0;
    logic [7:0] i_data = 8'd0;

    logic [7:0] rom [256];
    logic [7:0] lbytes [SS_LEN];
    logic [7:0] rd_p0 = 8'd0, rd_p1 = 8'd0;
    int tests = 0;
    int fails = 0;

    map_ss_seq #(.SS_LEN(SS_LEN), .RD_LAT(RD_LAT), .M2_TMO(M2_TMO)) dut (
        .clk(clk), .rst(rst), .start_save(start_save), .start_load(start_load),
        .abort(abort), .m2_fall(m2_fall), .ss_act(ss_act), .ss_we(ss_we),
        .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Mapper read port: data for an address appears two clocks after the address.
    always @(posedge clk) begin
        rd_p0 <= rom[ss_addr];
        rd_p1 <= rd_p0;
    end
    assign ss_rdat = rd_p1;

    task automatic pulse_start(input bit sv, input bit ld);
        @(negedge clk);
        start_save = sv;
        start_load = ld;
        @(negedge clk);
        start_save = 1'b0;
        start_load = 1'b0;
    endtask

    task automatic run_save(input string tag, input int mode, input bit both);
        int beats = 0, stall = 0, we_seen = 0, stab_bad = 0, early_done = 0;
        bit prev_hold = 1'b0, exp_done = 1'b0, fin = 1'b0, rdy;
        logic [7:0] prev_data = 8'd0, prev_addr = 8'd0;
        o_ready = 1'b0;
        pulse_start(1'b1, both);
        tests++;
        if (ss_act !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin
            fails++;
            $display("FAIL %s start act/busy/err got=%b%b%b exp=110", tag, ss_act, busy, err);
        end
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            start_load = (mode == 2 && cyc == 3);
            if (ss_we || i_ready) we_seen++;
            if (exp_done) begin
                tests++;
                if (done !== 1'b1 || ss_act !== 1'b0) begin
                    fails++;
                    $display("FAIL %s done_after_last done=%b act=%b exp done=1 act=0", tag, done, ss_act);
                end
                fin = 1'b1;
            end else begin
                if (done) early_done++;
                if (prev_hold && (o_valid !== 1'b1 || o_data !== prev_data || ss_addr !== prev_addr))
                    stab_bad++;
                if (mode == 1 && o_valid && ss_addr == 8'd2 && stall < 5) begin
                    rdy = 1'b0;
                    stall++;
                end else if (mode == 2) begin
                    rdy = 1'($urandom % 2);
                end else begin
                    rdy = 1'b1;
                end
                o_ready = rdy;
                if (o_valid && rdy) begin
                    tests++;
                    if (ss_addr !== 8'(beats) || o_data !== rom[beats]) begin
                        fails++;
                        $display("FAIL %s beat%0d addr=%h data=%h exp addr=%h data=%h",
                                 tag, beats, ss_addr, o_data, 8'(beats), rom[beats]);
                    end
                    beats++;
                    if (beats == SS_LEN) exp_done = 1'b1;
                end
                prev_hold = o_valid && !rdy;
                prev_data = o_data;
                prev_addr = ss_addr;
            end
        end
        o_ready = 1'b0;
        start_load = 1'b0;
        tests++;
        if (!fin) begin
            fails++;
            $display("FAIL %s timeout beats=%0d exp=%0d", tag, beats, SS_LEN);
        end
        tests++;
        if (we_seen != 0 || stab_bad != 0 || early_done != 0) begin
            fails++;
            $display("FAIL %s side we_or_iready=%0d unstable=%0d early_done=%0d exp all 0",
                     tag, we_seen, stab_bad, early_done);
        end
        if (mode == 1) begin
            tests++;
            if (stall != 5) begin
                fails++;
                $display("FAIL %s stall_cycles got=%0d exp=5", tag, stall);
            end
        end
    endtask

    task automatic run_load(input string tag, input int mode);
        int sent = 0, widx = 0, wlen = 0, m2_in = 0, m2_pos = -1, gap = 3;
        int done_at = -1, act_bad = 0, early_done = 0;
        bit fin = 1'b0, prev_wm2 = 1'b0;
        i_valid = 1'b0;
        m2_fall = 1'b0;
        pulse_start(1'b0, 1'b1);
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            @(negedge clk);
            if (ss_we) begin
                if (!ss_act) act_bad++;
            end else if (wlen > 0) begin
                tests++;
                if (m2_in != 1 || m2_pos != wlen - 2) begin
                    fails++;
                    $display("FAIL %s we_window m2_count=%0d m2_pos=%0d len=%0d exp count=1 pos=len-2",
                             tag, m2_in, m2_pos, wlen);
                end
                wlen = 0;
                m2_in = 0;
            end
            if (cyc == done_at) begin
                tests++;
                if (done !== 1'b1 || ss_act !== 1'b0) begin
                    fails++;
                    $display("FAIL %s done_pulse done=%b act=%b exp done=1 act=0", tag, done, ss_act);
                end
                fin = 1'b1;
            end else begin
                if (done) early_done++;
                if (mode == 0) begin
                    m2_fall = (cyc % 7 == 6);
                end else begin
                    gap--;
                    m2_fall = (gap == 0);
                    if (gap == 0) gap = $urandom_range(2, 10);
                end
                if (prev_wm2) m2_fall = 1'b0;
                prev_wm2 = ss_we && m2_fall;
                if (ss_we) begin
                    if (m2_fall) begin
                        m2_in++;
                        m2_pos = wlen;
                    end
                    wlen++;
                end
                if (ss_we && m2_fall) begin
                    tests++;
                    if (widx >= SS_LEN || ss_addr !== 8'(widx) || ss_wdat !== lbytes[widx % SS_LEN]) begin
                        fails++;
                        $display("FAIL %s write%0d addr=%h wdat=%h exp addr=%h wdat=%h",
                                 tag, widx, ss_addr, ss_wdat, 8'(widx), lbytes[widx % SS_LEN]);
                    end
                    widx++;
                    if (widx == SS_LEN) done_at = cyc + 2;
                end
                i_valid = (sent < SS_LEN) && (mode == 0 || ($urandom % 2) == 1);
                i_data  = lbytes[sent % SS_LEN];
                if (i_valid && i_ready) sent++;
            end
        end
        i_valid = 1'b0;
        m2_fall = 1'b0;
        tests++;
        if (!fin || act_bad != 0 || early_done != 0) begin
            fails++;
            $display("FAIL %s completion fin=%0d writes=%0d act_gaps=%0d early_done=%0d exp fin=1 writes=%0d 0 0",
                     tag, fin, widx, act_bad, early_done, SS_LEN);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({ss_act, ss_we, o_valid, i_ready, busy, done, err} !== 7'd0) begin
            fails++;
            $display("FAIL reset_flags got=%b exp=0000000", {ss_act, ss_we, o_valid, i_ready, busy, done, err});
        end
        tests++;
        if (ss_addr !== 8'd0 || ss_wdat !== 8'd0) begin
            fails++;
            $display("FAIL reset_addr_wdat got=%h/%h exp=00/00", ss_addr, ss_wdat);
        end
        rst = 1'b0;
    endtask

    task automatic test_save_basic();
        for (int a = 0; a < 256; a++) rom[a] = 8'(a * 3);
        run_save("save_basic", 0, 1'b0);
    endtask

    task automatic test_save_stall();
        for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
        run_save("save_stall", 1, 1'b0);
    endtask

    task automatic test_save_random();
        for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
        run_save("save_random", 2, 1'b0);
    endtask

    task automatic test_load_basic();
        lbytes[0] = 8'hA5;
        lbytes[1] = 8'h5A;
        lbytes[2] = 8'hFF;
        lbytes[3] = 8'h00;
        run_load("load_basic", 0);
    endtask

    task automatic test_load_random();
        for (int a = 0; a < SS_LEN; a++) lbytes[a] = 8'($urandom);
        run_load("load_random", 1);
    endtask

    task automatic test_timeout();
        int we_cnt = 0, done_seen = 0;
        bit dropped = 1'b0;
        m2_fall = 1'b0;
        i_valid = 1'b0;
        pulse_start(1'b0, 1'b1);
        for (int cyc = 0; cyc < 100 && !dropped; cyc++) begin
            @(negedge clk);
            if (done) done_seen++;
            if (ss_we) we_cnt++;
            else if (we_cnt > 0) dropped = 1'b1;
            if (!dropped) begin
                i_valid = (we_cnt == 0);
                i_data  = 8'($urandom);
            end
        end
        i_valid = 1'b0;
        tests++;
        if (!dropped || we_cnt != M2_TMO) begin
            fails++;
            $display("FAIL timeout_len we_cycles=%0d dropped=%0d exp=%0d/1", we_cnt, dropped, M2_TMO);
        end
        tests++;
        if (err !== 1'b1 || ss_act !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_state err=%b act=%b busy=%b exp=1/0/0", err, ss_act, busy);
        end
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        tests++;
        if (err !== 1'b1 || done_seen != 0) begin
            fails++;
            $display("FAIL timeout_sticky err=%b done_pulses=%0d exp=1/0", err, done_seen);
        end
    endtask

    task automatic test_abort();
        bit hit = 1'b0;
        for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
        o_ready = 1'b1;
        pulse_start(1'b1, 1'b0);
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL abort_err_clear got=%b exp=0", err);
        end
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            @(negedge clk);
            if (ss_addr == 8'd2) hit = 1'b1;
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        o_ready = 1'b0;
        tests++;
        if (!hit || busy !== 1'b0 || ss_act !== 1'b0 || ss_addr !== 8'd0 ||
            o_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle hit=%0d busy=%b act=%b addr=%h ov=%b done=%b err=%b exp 1 0 0 00 0 0 0",
                     hit, busy, ss_act, ss_addr, o_valid, done, err);
        end
        run_save("abort_restart", 2, 1'b0);
    endtask

    task automatic test_rst_mid();
        bit armed = 1'b0;
        m2_fall = 1'b0;
        pulse_start(1'b0, 1'b1);
        for (int cyc = 0; cyc < 50 && !armed; cyc++) begin
            @(negedge clk);
            if (ss_we) armed = 1'b1;
            i_valid = !armed;
            i_data  = 8'h3C;
        end
        i_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (!armed || ss_we !== 1'b0 || ss_act !== 1'b0 || busy !== 1'b0 || ss_addr !== 8'd0) begin
            fails++;
            $display("FAIL rst_mid armed=%0d we=%b act=%b busy=%b addr=%h exp 1 0 0 0 00",
                     armed, ss_we, ss_act, busy, ss_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
        run_save("both_starts", 0, 1'b1);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 8'd0;
        for (int a = 0; a < SS_LEN; a++) lbytes[a] = 8'd0;
        test_reset();
        test_save_basic();
        test_save_stall();
        test_save_random();
        test_load_basic();
        test_load_random();
        test_timeout();
        test_abort();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
